// File: rtl/em_arbiter.sv
// Round-robin arbiter that lets NUM_REQ spin requesters share one energy monitor,
// with at most one spin/energy transaction in flight.
module em_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SPINW   = 256,
  parameter int ENERGYW = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*SPINW-1:0]   req_spin_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       em_spin_valid_o,
  output logic [SPINW-1:0]           em_spin_o,
  input  logic                       em_spin_ready_i,
  input  logic                       em_energy_valid_i,
  input  logic [ENERGYW-1:0]         em_energy_i,
  output logic                       em_energy_ready_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [ENERGYW-1:0]         rsp_energy_o,
  input  logic [NUM_REQ-1:0]         rsp_ready_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     last_id_q, last_id_d;
  logic [ENERGYW-1:0] rsp_energy_q, rsp_energy_d;

  // First set valid bit found scanning upward from the requester after 'last'.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     last);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!found && valid[idx]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_id_q    <= IDW'(NUM_REQ - 1);
      rsp_energy_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_id_q    <= last_id_d;
      rsp_energy_q <= rsp_energy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_id_d    = last_id_q;
    rsp_energy_d = rsp_energy_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i && (|req_valid_i)) begin
          grant_id_d = rr_pick(req_valid_i, last_id_q);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!en_i)                state_d = ST_IDLE;
        else if (em_spin_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (em_energy_valid_i) begin
          rsp_energy_d = em_energy_i;
          state_d      = ST_RETURN;
        end
      end
      ST_RETURN: begin
        // Fairness pointer only advances on a completed response handshake.
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (rsp_ready_i[grant_id_q]) begin
          last_id_d = grant_id_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are gated by en_i so an abort cycle shows no valid/ready.
  always_comb begin
    req_ready_o       = '0;
    em_spin_valid_o   = 1'b0;
    em_spin_o         = '0;
    em_energy_ready_o = 1'b0;
    rsp_valid_o       = '0;
    busy_o            = (state_q != ST_IDLE);
    if (en_i) begin
      case (state_q)
        ST_ISSUE: begin
          em_spin_valid_o         = 1'b1;
          em_spin_o               = req_spin_i[int'(grant_id_q)*SPINW +: SPINW];
          req_ready_o[grant_id_q] = em_spin_ready_i;
        end
        ST_WAIT:   em_energy_ready_o       = 1'b1;
        ST_RETURN: rsp_valid_o[grant_id_q] = 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_energy_o = rsp_energy_q;
  assign grant_id_o   = grant_id_q;

endmodule

// File: tb/tb_em_arbiter.sv
// Self-checking bench for em_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_em_arbiter;

  localparam int N  = 4;
  localparam int SW = 256;
  localparam int EW = 32;

  typedef logic [300:0] ovec_t;

  typedef struct {
    logic        en;
    logic [3:0]  rv;
    logic        sr;
    logic        ev;
    logic [31:0] egy;
    logic [3:0]  rr;
    ovec_t       exp;
  } vec_t;

  localparam logic [255:0] S0  = {8{32'hC0C0_0000}};
  localparam logic [255:0] S1  = {8{32'h1111_1111}};
  localparam logic [255:0] SA5 = {32{8'hA5}};
  localparam logic [255:0] S3  = {8{32'h3333_3333}};

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            en_i;
  logic [N-1:0]    req_valid_i;
  logic [N*SW-1:0] req_spin_i;
  logic [N-1:0]    req_ready_o;
  logic            em_spin_valid_o;
  logic [SW-1:0]   em_spin_o;
  logic            em_spin_ready_i;
  logic            em_energy_valid_i;
  logic [EW-1:0]   em_energy_i;
  logic            em_energy_ready_o;
  logic [N-1:0]    rsp_valid_o;
  logic [EW-1:0]   rsp_energy_o;
  logic [N-1:0]    rsp_ready_i;
  logic            busy_o;
  logic [1:0]      grant_id_o;

  int checks = 0;
  int errors = 0;

  em_arbiter #(.NUM_REQ(N), .SPINW(SW), .ENERGYW(EW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .en_i             (en_i),
    .req_valid_i      (req_valid_i),
    .req_spin_i       (req_spin_i),
    .req_ready_o      (req_ready_o),
    .em_spin_valid_o  (em_spin_valid_o),
    .em_spin_o        (em_spin_o),
    .em_spin_ready_i  (em_spin_ready_i),
    .em_energy_valid_i(em_energy_valid_i),
    .em_energy_i      (em_energy_i),
    .em_energy_ready_o(em_energy_ready_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_energy_o     (rsp_energy_o),
    .rsp_ready_i      (rsp_ready_i),
    .busy_o           (busy_o),
    .grant_id_o       (grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic ovec_t mk(logic busy, logic sv, logic [3:0] rdy, logic er,
                               logic [3:0] rsv, logic [1:0] gid, logic [31:0] egy,
                               logic [255:0] spin);
    return {busy, sv, rdy, er, rsv, gid, egy, spin};
  endfunction

  function automatic ovec_t act();
    return mk(busy_o, em_spin_valid_o, req_ready_o, em_energy_ready_o, rsp_valid_o,
              grant_id_o, rsp_energy_o, em_spin_o);
  endfunction

  task automatic chk_vec(input string nm, input ovec_t a, input ovec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    en_i              = 1'b1;
    req_valid_i       = '0;
    em_spin_ready_i   = 1'b0;
    em_energy_valid_i = 1'b0;
    em_energy_i       = '0;
    rsp_ready_i       = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Full transaction with every handshake partner ready: four clock edges.
  task automatic run_txn(input logic [3:0] rv);
    req_valid_i       = rv;
    em_spin_ready_i   = 1'b1;
    em_energy_valid_i = 1'b1;
    em_energy_i       = 32'h0000_BEEF;
    rsp_ready_i       = 4'hF;
    repeat (4) tick();
    idle_inputs();
  endtask

  // Reference model state
  int          m_ph;
  int          m_gid;
  int          m_last;
  logic [31:0] m_egy;

  function automatic ovec_t model_out();
    logic [3:0]   rdy;
    logic [3:0]   rsv;
    logic [255:0] spin;
    logic         sv;
    logic         er;
    rdy  = '0;
    rsv  = '0;
    spin = '0;
    sv   = 1'b0;
    er   = 1'b0;
    if (en_i && m_ph == 1) begin
      sv         = 1'b1;
      spin       = req_spin_i[m_gid*SW +: SW];
      rdy[m_gid] = em_spin_ready_i;
    end
    if (en_i && m_ph == 2) er = 1'b1;
    if (en_i && m_ph == 3) rsv[m_gid] = 1'b1;
    return mk(m_ph != 0, sv, rdy, er, rsv, 2'(m_gid), m_egy, spin);
  endfunction

  task automatic model_step();
    logic found;
    case (m_ph)
      0: if (en_i && req_valid_i != 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid_i[(m_last + k) % N]) begin
            m_gid = (m_last + k) % N;
            found = 1'b1;
          end
        end
        m_ph = 1;
      end
      1: if (!en_i) m_ph = 0; else if (em_spin_ready_i) m_ph = 2;
      2: if (!en_i) m_ph = 0; else if (em_energy_valid_i) begin
        m_egy = em_energy_i;
        m_ph  = 3;
      end
      default: if (!en_i) m_ph = 0; else if (rsp_ready_i[m_gid]) begin
        m_last = m_gid;
        m_ph   = 0;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tv[12];
    ovec_t e_idle0, e_stall, e_hs, e_wait, e_ret, e_idle2;
    int    exp_order[5];
    int    n;
    int    hs;

    req_spin_i = {S3, SA5, S1, S0};
    idle_inputs();

    // Single requester 2 through a stalled issue, energy capture and response.
    e_idle0 = mk(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 32'h0, '0);
    e_stall = mk(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 32'h0, SA5);
    e_hs    = mk(1'b1, 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2, 32'h0, SA5);
    e_wait  = mk(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 32'h0, '0);
    e_ret   = mk(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 32'hFFFF_FF10, '0);
    e_idle2 = mk(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 32'hFFFF_FF10, '0);
    tv[0]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 32'h0, 4'b0000, e_idle0};
    tv[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 32'h0, 4'b0000, e_stall};
    tv[2]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 32'h0, 4'b0000, e_stall};
    tv[3]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 32'h0, 4'b0000, e_stall};
    tv[4]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 32'h0, 4'b0000, e_stall};
    tv[5]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 32'h0, 4'b0000, e_stall};
    tv[6]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 32'h0, 4'b0000, e_hs};
    tv[7]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, e_wait};
    tv[8]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 32'hFFFF_FF10, 4'b0000, e_wait};
    tv[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, e_ret};
    tv[10] = '{1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0100, e_ret};
    tv[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, e_idle2};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      en_i              = tv[i].en;
      req_valid_i       = tv[i].rv;
      em_spin_ready_i   = tv[i].sr;
      em_energy_valid_i = tv[i].ev;
      em_energy_i       = tv[i].egy;
      rsp_ready_i       = tv[i].rr;
      #1;
      chk_vec($sformatf("vec%0d", i), act(), tv[i].exp);
      tick();
    end

    // All four requesting, energy two cycles after each spin handshake.
    do_reset();
    exp_order       = '{0, 1, 2, 3, 0};
    req_valid_i     = 4'hF;
    em_spin_ready_i = 1'b1;
    rsp_ready_i     = 4'hF;
    n  = 0;
    hs = -10;
    for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
      em_energy_valid_i = (cyc == hs + 2);
      em_energy_i       = 32'(100 + n);
      #1;
      if (em_spin_valid_o && em_spin_ready_i) hs = cyc;
      if (rsp_valid_o != '0) begin
        chk_int($sformatf("rr_route%0d", n), int'(rsp_valid_o), 1 << exp_order[n]);
        chk_int($sformatf("rr_grant%0d", n), int'(grant_id_o), exp_order[n]);
        chk_int($sformatf("rr_energy%0d", n), int'(rsp_energy_o), 100 + n);
        n++;
      end
      tick();
    end
    chk_int("rr_completed", n, 5);
    idle_inputs();

    // Enable dropped in WAIT: abort, then the same winner is granted again.
    do_reset();
    req_valid_i     = 4'b0011;
    em_spin_ready_i = 1'b1;
    tick();
    tick();
    en_i = 1'b0;
    #1;
    chk_vec("abort_in_wait", act(), mk(1'b1, 1'b0, 4'b0, 1'b0, 4'b0, 2'd0, 32'h0, '0));
    tick();
    #1;
    chk_vec("abort_idle", act(), mk(1'b0, 1'b0, 4'b0, 1'b0, 4'b0, 2'd0, 32'h0, '0));
    en_i            = 1'b1;
    em_spin_ready_i = 1'b0;
    tick();
    #1;
    chk_vec("abort_regrant", act(), mk(1'b1, 1'b1, 4'b0, 1'b0, 4'b0, 2'd0, 32'h0, S0));
    idle_inputs();

    // Response held by rsp_ready low while requester 0 waits.
    do_reset();
    run_txn(4'b0001);
    req_valid_i       = 4'b0011;
    em_spin_ready_i   = 1'b1;
    em_energy_valid_i = 1'b1;
    em_energy_i       = 32'h0000_1234;
    tick();
    tick();
    tick();
    em_energy_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_vec($sformatf("hold_rsp%0d", i), act(),
              mk(1'b1, 1'b0, 4'b0, 1'b0, 4'b0010, 2'd1, 32'h1234, '0));
      tick();
    end
    rsp_ready_i = 4'b0010;
    #1;
    chk_vec("hold_release", act(), mk(1'b1, 1'b0, 4'b0, 1'b0, 4'b0010, 2'd1, 32'h1234, '0));
    tick();
    em_spin_ready_i = 1'b0;
    rsp_ready_i     = 4'b0000;
    #1;
    chk_vec("hold_idle", act(), mk(1'b0, 1'b0, 4'b0, 1'b0, 4'b0, 2'd1, 32'h1234, '0));
    tick();
    #1;
    chk_vec("hold_next", act(), mk(1'b1, 1'b1, 4'b0, 1'b0, 4'b0, 2'd0, 32'h1234, S0));
    idle_inputs();

    // Asynchronous reset in ISSUE discards the transaction.
    do_reset();
    run_txn(4'b0010);
    req_valid_i = 4'b0100;
    tick();
    #1;
    chk_vec("rst_pre", act(), mk(1'b1, 1'b1, 4'b0, 1'b0, 4'b0, 2'd2, 32'hBEEF, SA5));
    rst_ni = 1'b0;
    #1;
    chk_vec("rst_async", act(), mk(1'b0, 1'b0, 4'b0, 1'b0, 4'b0, 2'd0, 32'h0, '0));
    tick();
    rst_ni      = 1'b1;
    req_valid_i = 4'hF;
    tick();
    #1;
    chk_vec("rst_first", act(), mk(1'b1, 1'b1, 4'b0, 1'b0, 4'b0, 2'd0, 32'h0, S0));
    idle_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    m_ph   = 0;
    m_gid  = 0;
    m_last = N - 1;
    m_egy  = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      en_i              = ($urandom_range(0, 9) != 0);
      req_valid_i       = 4'($urandom_range(0, 15));
      em_spin_ready_i   = 1'($urandom_range(0, 1));
      em_energy_valid_i = 1'($urandom_range(0, 1));
      em_energy_i       = $urandom();
      rsp_ready_i       = 4'($urandom_range(0, 15));
      for (int w = 0; w < 32; w++) req_spin_i[w*32 +: 32] = $urandom();
      #1;
      chk_vec($sformatf("rand%0d", cyc), act(), model_out());
      model_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
